// File: rtl/scope_pkg.sv
// Shared widths, FSM encoding, table entry layout and DAC scaling for the scope point renderer.
package scope_pkg;

  localparam int X_W   = 7;
  localparam int Y_W   = 6;
  localparam int DAC_W = 8;
  localparam int N_OBJ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DWELL} state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  function automatic logic [DAC_W-1:0] x_to_dac(input logic [X_W-1:0] x);
    return {x, 1'b0};
  endfunction

  function automatic logic [DAC_W-1:0] y_to_dac(input logic [Y_W-1:0] y);
    return {y, 2'b00};
  endfunction

endpackage

// File: rtl/next_valid_picker.sv
// Rotating priority encoder: first set mask bit strictly above cur_idx, wrapping 7->0.
// Combinational, no backpressure; wrapped=1 when the pick is at or below cur_idx.
module next_valid_picker
  import scope_pkg::*;
(
  input  logic [N_OBJ-1:0] valid_mask,
  input  logic [IDX_W-1:0] cur_idx,
  output logic [IDX_W-1:0] next_idx,
  output logic             wrapped
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    next_idx = cur_idx;
    wrapped  = 1'b1;
    found    = 1'b0;
    cand     = cur_idx;
    // k runs to N_OBJ so a lone valid entry re-selects itself.
    for (int k = 1; k <= N_OBJ; k++) begin
      cand = cur_idx + IDX_W'(k);
      if (!found && valid_mask[cand]) begin
        found    = 1'b1;
        next_idx = cand;
        wrapped  = (cand <= cur_idx);
      end
    end
  end

endmodule

// File: rtl/scope_point_renderer.sv
// Redraws every valid table entry as a blanked-settle/unblanked-dwell dot on XY DACs; updates never stall.
// Outputs registered; frame_start and new DAC codes appear together the cycle after LOAD. Option: SCOPE_RENDER_CROSSHAIR_EN.
module scope_point_renderer
  import scope_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_index,
  input  logic [X_W-1:0]   in_x,
  input  logic [Y_W-1:0]   in_y,
  output logic [DAC_W-1:0] dac_x,
  output logic [DAC_W-1:0] dac_y,
  output logic             blank,
  output logic             frame_start
);

  pos_t             tbl [N_OBJ];
  logic [N_OBJ-1:0] tbl_vld;
  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_wrap;
  pos_t             pick_pos;
  pos_t             beam;

  next_valid_picker u_picker (
    .valid_mask (tbl_vld),
    .cur_idx    (cur_idx),
    .next_idx   (pick_idx),
    .wrapped    (pick_wrap)
  );

  assign pick_pos = tbl[pick_idx];
  assign dac_x    = x_to_dac(beam.x);
  assign dac_y    = y_to_dac(beam.y);

`ifdef SCOPE_RENDER_CROSSHAIR_EN
  logic [2:0] sub_idx;
  pos_t       centre;
  pos_t       sub_pos;

  // Arm offsets saturate at the screen edge rather than wrapping to the far side.
  always_comb begin
    sub_pos = centre;
    case (sub_idx)
      3'd1: if (centre.x != '1) sub_pos.x = centre.x + 1'b1;
      3'd2: if (centre.x != '0) sub_pos.x = centre.x - 1'b1;
      3'd3: if (centre.y != '1) sub_pos.y = centre.y + 1'b1;
      3'd4: if (centre.y != '0) sub_pos.y = centre.y - 1'b1;
      default: ;
    endcase
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|tbl_vld) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
      SETTLE: begin
        if (cnt == 8'(SETTLE_CYCLES - 1)) begin
          state_nxt = DWELL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DWELL: begin
        if (cnt == 8'(DWELL_CYCLES - 1)) begin
          state_nxt = (|tbl_vld) ? LOAD : IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Entry payload needs no reset; only the valid bits gate its use.
  always_ff @(posedge clock) begin
    if (reset && in_valid && in_ready) tbl[in_index] <= '{x: in_x, y: in_y};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tbl_vld     <= '0;
      state       <= IDLE;
      cnt         <= '0;
      cur_idx     <= IDX_W'(N_OBJ - 1);
      beam        <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      in_ready    <= 1'b0;
`ifdef SCOPE_RENDER_CROSSHAIR_EN
      sub_idx     <= '0;
      centre      <= '0;
`endif
    end else begin
      in_ready    <= 1'b1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      blank       <= (state_nxt != DWELL);
      frame_start <= 1'b0;
      if (in_valid && in_ready) tbl_vld[in_index] <= 1'b1;
      // Parking at the top index makes the first pick out of IDLE the lowest valid one, flagged as a wrap.
      if (state == IDLE) cur_idx <= IDX_W'(N_OBJ - 1);
`ifdef SCOPE_RENDER_CROSSHAIR_EN
      if (state == IDLE) begin
        sub_idx <= '0;
      end else if (state == DWELL && state_nxt != DWELL) begin
        sub_idx <= (sub_idx == 3'd4) ? 3'd0 : sub_idx + 3'd1;
      end
      if (state == LOAD) begin
        if (sub_idx == 3'd0) begin
          cur_idx     <= pick_idx;
          centre      <= pick_pos;
          beam        <= pick_pos;
          frame_start <= pick_wrap;
        end else begin
          beam <= sub_pos;
        end
      end
`else
      if (state == LOAD) begin
        cur_idx     <= pick_idx;
        beam        <= pick_pos;
        frame_start <= pick_wrap;
      end
`endif
    end
  end

endmodule

// File: tb/tb_scope_point_renderer.sv
// Directed bench for scope_point_renderer at default timing (settle 16, dwell 64, 81-cycle dot).
module tb_scope_point_renderer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_index = '0;
  logic [6:0] in_x = '0;
  logic [5:0] in_y = '0;
  logic [7:0] dac_x, dac_y;
  logic       blank, frame_start;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  scope_point_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_index    (in_index),
    .in_x        (in_x),
    .in_y        (in_y),
    .dac_x       (dac_x),
    .dac_y       (dac_y),
    .blank       (blank),
    .frame_start (frame_start)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int idx, input int x, input int y);
    in_index = 3'(idx);
    in_x     = 7'(x);
    in_y     = 6'(y);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_fs(input int bound, output int n);
    n = 0;
    while (frame_start !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int fs_cnt;
    int bad;
    int low;

    // Reset state and a quiet idle period.
    reset = 1'b0;
    tick();
    tick();
    chk("rst_blank", blank, 1);
    chk("rst_dac_x", dac_x, 0);
    chk("rst_dac_y", dac_y, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    chk("in_ready_after_rst", in_ready, 1);
    fs_cnt = 0;
    bad    = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (frame_start === 1'b1) fs_cnt++;
      if (blank !== 1'b1 || dac_x !== 8'd0 || dac_y !== 8'd0) bad++;
    end
    chk("idle_frame_starts", fs_cnt, 0);
    chk("idle_output_glitches", bad, 0);

`ifdef SCOPE_RENDER_CROSSHAIR_EN
    begin
      int ex[5] = '{0, 2, 0, 0, 0};
      int ey[5] = '{252, 252, 252, 252, 248};
      put(1, 0, 63);
      wait_fs(200, n);
      chk("xh_fs_timeout", 32'(n < 200), 1);
      for (int i = 0; i < 5; i++) begin
        if (i > 0) repeat (81) tick();
        chk($sformatf("xh_dac_x_%0d", i), dac_x, ex[i]);
        chk($sformatf("xh_dac_y_%0d", i), dac_y, ey[i]);
        chk($sformatf("xh_fs_%0d", i), frame_start, (i == 0) ? 1 : 0);
      end
      repeat (81) tick();
      chk("xh_fs_next_pass", frame_start, 1);
      chk("xh_dac_x_next_pass", dac_x, 0);
    end
`else
    // Single entry: 16 blanked, 64 lit, 81-cycle repeat.
    put(3, 10, 20);
    wait_fs(200, n);
    chk("one_fs_timeout", 32'(n < 200), 1);
    chk("one_dac_x", dac_x, 20);
    chk("one_dac_y", dac_y, 80);
    chk("one_blank_at_load", blank, 1);
    n = 0;
    while (blank !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("one_settle_len", n, 16);
    low = 0;
    while (blank === 1'b0 && low < 300) begin
      tick();
      low++;
    end
    chk("one_dwell_len", low, 64);
    chk("one_fs_before_period", frame_start, 0);
    tick();
    chk("one_fs_period_81", frame_start, 1);
    chk("one_dac_x_repeat", dac_x, 20);

    // Rewrite of the entry being drawn waits for its next visit.
    repeat (26) tick();
    put(3, 11, 20);
    chk("shadow_hold_early", dac_x, 20);
    repeat (53) tick();
    chk("shadow_hold_late", dac_x, 20);
    tick();
    chk("shadow_next_fs", frame_start, 1);
    chk("shadow_next_dac_x", dac_x, 22);

    // Two entries at the extremes alternate; frame_start only on idx 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    put(0, 127, 63);
    put(7, 0, 0);
    wait_fs(200, n);
    chk("two_fs_timeout", 32'(n < 200), 1);
    chk("two_dac_x_idx0", dac_x, 254);
    chk("two_dac_y_idx0", dac_y, 252);
    repeat (81) tick();
    chk("two_dac_x_idx7", dac_x, 0);
    chk("two_dac_y_idx7", dac_y, 0);
    chk("two_fs_idx7", frame_start, 0);
    repeat (81) tick();
    chk("two_fs_idx0_again", frame_start, 1);
    chk("two_dac_x_idx0_again", dac_x, 254);

    // Reset during a lit dwell blanks immediately and stays idle.
    repeat (40) tick();
    chk("mid_blank_before_rst", blank, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_blank", blank, 1);
    chk("mid_rst_dac_x", dac_x, 0);
    chk("mid_rst_dac_y", dac_y, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    fs_cnt = 0;
    low    = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (frame_start === 1'b1) fs_cnt++;
      if (blank === 1'b0) low++;
    end
    chk("post_rst_frame_starts", fs_cnt, 0);
    chk("post_rst_lit_cycles", low, 0);
    put(5, 1, 1);
    wait_fs(200, n);
    chk("post_rst_fs_timeout", 32'(n < 200), 1);
    chk("post_rst_dac_x", dac_x, 2);
    chk("post_rst_dac_y", dac_y, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_point_renderer.md
# scope_point_renderer

Downstream stage of the gravity simulator: it accepts per-object position updates and continuously redraws every known object as a dot on an XY-mode oscilloscope. Each dot is drawn with a blanked settle period followed by an unblanked dwell. Output drives two 8-bit DACs (X, Y) plus a Z-axis blank line. The block decouples the slow physics update rate from the fast refresh rate, so all objects stay visible between updates.

## Interface
- `SETTLE_CYCLES`, default 16: cycles with `blank`=1 after the DAC codes change; range 1..255.
- `DWELL_CYCLES`, default 64: cycles with `blank`=0 per dot; range 1..255.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous reset, active-low.
- `in_valid`  in  1  position update present.
- `in_ready`  out  1  update accepted when `in_valid`&`in_ready`.
- `in_index`  in  3  object number, 0..7.
- `in_x`  in  7  x position, unsigned, 0..127.
- `in_y`  in  6  y position, unsigned, 0..63.
- `dac_x`  out  8  X DAC code.
- `dac_y`  out  8  Y DAC code.
- `blank`  out  1  1 = beam off.
- `frame_start`  out  1  one-cycle pulse at the start of each refresh pass.

## Operation
- Table: 8 entries of {x[6:0], y[5:0], valid}. At reset every valid bit is 0. An accepted update writes entry `in_index` and sets its valid bit. Later writes to the same index overwrite the entry.
- `in_ready` is 0 while `reset`=0 and 1 otherwise; updates are never stalled.
- Scaling: `dac_x` = {x, 1'b0}; `dac_y` = {y, 2'b00}.
- FSM states:
  - IDLE: no valid entries. `blank`=1, DAC outputs hold their last value.
  - LOAD: selects the next valid index above the current one in ascending order, wrapping 7→0. It latches that entry into a shadow register, drives the DACs from the shadow, and goes to SETTLE.
  - SETTLE: counts `SETTLE_CYCLES`, then goes to DWELL.
  - DWELL: `blank`=0 and counts `DWELL_CYCLES`. Then goes to LOAD, or to IDLE if no entry is valid.
- Shadow rule: an update to the entry currently being drawn does not move the beam mid-dot. It takes effect on that entry's next visit.
- `frame_start` pulses in the LOAD cycle that selects the lowest valid index after a wrap, or after leaving IDLE.
- Single valid entry: LOAD re-selects the same entry, and `frame_start` pulses on every pass.
- Reset mid-operation: the table is invalidated, FSM goes to IDLE, counters clear.
- Reset values: `dac_x`=0, `dac_y`=0, `blank`=1, `frame_start`=0, `in_ready`=0.

## Timing
- All outputs are registered.
- An update accepted in cycle n is visible in the table at n+1. It is eligible for the next LOAD at or after n+1.
- Per dot: 1 LOAD + `SETTLE_CYCLES` + `DWELL_CYCLES` cycles. `blank` deasserts exactly `SETTLE_CYCLES`+1 cycles after the LOAD cycle.
- Refresh period = valid_count × (1 + `SETTLE_CYCLES` + `DWELL_CYCLES`).
- Same-cycle update and LOAD of the same index: LOAD uses the old table value; the update takes effect on the following visit.

## Configuration
- `SCOPE_RENDER_CROSSHAIR_EN`:
  - Defined: each object is drawn as 5 sub-dots in the order centre, x+1, x−1, y+1, y−1. Each sub-dot gets its own settle and dwell. Offsets clamp at 0/127 (x) and 0/63 (y), never wrap. `frame_start` still pulses once per pass, on the centre sub-dot.
  - Undefined: one dot per object; sub-dot logic is absent.

## Structure
- Shared package `scope_pkg`:
  - width constants X_W=7, Y_W=6, DAC_W=8, N_OBJ=8.
  - FSM state enum {IDLE, LOAD, SETTLE, DWELL}.
  - Scaling functions x_to_dac and y_to_dac.
- One sub-module, `next_valid_picker`: combinational rotating priority encoder. Inputs: valid mask and current index. Outputs: next index and a wrapped flag.

## Test plan
- Reset, no updates → `blank`=1, `dac_x`=`dac_y`=0, `frame_start` never pulses over 1000 cycles.
- Write idx 3 (x=10, y=20), defaults → `dac_x`=20, `dac_y`=80, `blank` low for 64 cycles each 81-cycle period, `frame_start` every 81 cycles.
- Write idx 0 (x=127, y=63) and idx 7 (x=0, y=0) → dots alternate 0,7,0,7. `dac` pairs are (254,252) then (0,0). `frame_start` fires only on idx 0.
- Rewrite idx 3 (x=11) mid-DWELL of idx 3 → `dac_x` stays 20 until the dot ends, then 22 on the next visit.
- Pulse `reset` low while two entries are drawing → next cycle `blank`=1, FSM in IDLE, and no dots appear until a new update arrives.
- With `SCOPE_RENDER_CROSSHAIR_EN`, write idx 1 (x=0, y=63) → `dac_x` sequence 0,2,0,0,0 and `dac_y` sequence 252,252,252,252,248.
